// File: rtl/spike_sched_pkg.sv
// Shared types and defaults for the spike FIFO scheduler.
// Optional feature macro: SPIKE_SCHED_PRIO0_EN (strict priority for requester 0).
package spike_sched_pkg;

    localparam int DEFAULT_NUM_REQ = 3;
    localparam int DEFAULT_N       = 256;

    // Read-side sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_e;

    // Index width that stays legal for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_fifo_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the
// pointer, wrapping back to index 0. Produces a one-hot grant and its index.
module rr_arbiter
    import spike_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    int w_cand;

    // Scan the ring starting at the pointer and keep the first hit
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = IW'(w_cand);
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_fifo_scheduler.sv
// Spike FIFO scheduler: arbitrates several spike-event sources onto one FIFO
// write port and streams FIFO contents to the neuron-update controller through
// a three-state read sequencer (IDLE -> FETCH -> HOLD).
// Optional feature macro: SPIKE_SCHED_PRIO0_EN -- requester 0 wins outright,
// the remaining requesters share the round-robin ring.
module spike_fifo_scheduler
    import spike_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    parameter  int N       = DEFAULT_N,
    localparam int AW      = $clog2(N),
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0][AW-1:0]  req_addr_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        FIFO_w_en_o,
    output logic [AW-1:0]               FIFO_w_data_o,
    input  logic                        FIFO_full_i,
    output logic                        FIFO_r_en_o,
    input  logic                        FIFO_empty_i,
    input  logic [AW-1:0]               FIFO_r_data_i,
    output logic                        spk_valid_o,
    input  logic                        spk_ready_i,
    output logic [AW-1:0]               spk_addr_o
);

    logic [IW-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_rr_grant;
    logic [IW-1:0]      w_rr_idx;
    logic               w_rr_any;
    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic               w_accept;
    logic               w_ptr_adv;
    logic [IW-1:0]      w_ptr_nxt;

    rd_state_e          r_state;
    rd_state_e          w_state_nxt;
    logic               w_r_en;
    logic               w_spk_valid;

    // ---------------- write side ----------------

    // Select which requests take part in the round-robin ring
    always_comb begin
        w_arb_req = req_valid_i;
`ifdef SPIKE_SCHED_PRIO0_EN
        w_arb_req[0] = 1'b0;
`endif
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .i_req   (w_arb_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    // Final grant, with the requester-0 override when priority is enabled
    always_comb begin
        w_grant   = w_rr_grant;
        w_idx     = w_rr_idx;
        w_any     = w_rr_any;
        w_ptr_adv = 1'b1;
`ifdef SPIKE_SCHED_PRIO0_EN
        if (req_valid_i[0]) begin
            w_grant   = '0;
            w_grant[0] = 1'b1;
            w_idx     = '0;
            w_any     = 1'b1;
            w_ptr_adv = 1'b0;
        end
`endif
    end

    // Outputs are held at zero while reset is asserted, independent of inputs
    assign w_accept      = RSTN && w_any && !FIFO_full_i;
    assign FIFO_w_en_o   = w_accept;
    assign req_ready_o   = w_accept ? w_grant : '0;
    assign FIFO_w_data_o = RSTN ? req_addr_i[w_idx] : '0;
    assign w_ptr_nxt     = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // Advance the ring pointer past the requester that just wrote
    always_ff @(posedge CLK or negedge RSTN) begin
        // NOTE: the async reset branch clears state the instant RSTN falls;
        // nothing here is a memory array, so every register is reset.
        if (!RSTN) begin
            r_rr_ptr <= '0;
        end else if (w_accept && w_ptr_adv) begin
            // NOTE: clocked state uses non-blocking assignment so all
            // registers sample pre-edge values regardless of block order.
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // ---------------- read side ----------------

    // Read sequencer state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, read strobe and spike-valid decode
    always_comb begin
        w_state_nxt = r_state;
        w_r_en      = 1'b0;
        w_spk_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (!FIFO_empty_i) begin
                    w_r_en      = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                w_spk_valid = 1'b1;
                if (spk_ready_i) begin
                    if (!FIFO_empty_i) begin
                        w_r_en      = 1'b1;
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FIFO read data stays put until the next read, so HOLD can present it directly
    assign FIFO_r_en_o = RSTN && w_r_en;
    assign spk_valid_o = w_spk_valid;
    assign spk_addr_o  = w_spk_valid ? FIFO_r_data_i : '0;

endmodule
